// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the per-cycle action encoding for the up/down Gray counter.
// Conversions operate on 32-bit words; callers cast to their own width.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_STEP  = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_CLEAR = 2'd3
  } gray_act_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_ud_if.sv
// Control/status bundle between the counter shell and its register core.
// master drives the controls and observes the counts; slave is the register core.
interface gray_counter_ud_if #(
  parameter int unsigned W = 4
);
  logic         clear_i;
  logic         load_i;
  logic         enable_i;
  logic         up_i;
  logic [W-1:0] load_value_i;
  logic [W-1:0] bin_o;
  logic [W-1:0] gray_o;
  logic         wrap_o;
  logic         zero_o;

  modport master (
    output clear_i, load_i, enable_i, up_i, load_value_i,
    input  bin_o, gray_o, wrap_o, zero_o
  );

  modport slave (
    input  clear_i, load_i, enable_i, up_i, load_value_i,
    output bin_o, gray_o, wrap_o, zero_o
  );
endinterface

// File: rtl/gray_encode_reg.sv
// Next-state selection, Gray encoding and output registers for gray_counter_ud.
// Define GRAY_COUNTER_UD_SATURATE_EN to saturate at the ends instead of wrapping.
module gray_encode_reg
  import gray_pkg::*;
#(
  parameter int unsigned W           = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  gray_counter_ud_if.slave bus
);

  localparam logic [W-1:0] RST_BIN  = W'(RESET_VALUE);
  localparam logic [W-1:0] RST_GRAY = W'(bin2gray(GRAY_MAX_W'(RST_BIN)));
  localparam logic [W-1:0] ONE      = W'(1);

  gray_act_e    act;
  logic         at_limit;
  logic [W-1:0] bin_q,  bin_d;
  logic [W-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;
  logic         zero_q, zero_d;

  always_comb begin
    if (bus.clear_i)       act = ACT_CLEAR;
    else if (bus.load_i)   act = ACT_LOAD;
    else if (bus.enable_i) act = ACT_STEP;
    else                   act = ACT_HOLD;
  end

  assign at_limit = bus.up_i ? (bin_q == '1) : (bin_q == '0);

  // Gray and zero flag derive from bin_d so all outputs update on the same edge.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    case (act)
      ACT_CLEAR: bin_d = RST_BIN;
      ACT_LOAD:  bin_d = bus.load_value_i;
      ACT_STEP: begin
        wrap_d = at_limit;
`ifdef GRAY_COUNTER_UD_SATURATE_EN
        if (!at_limit) begin
          bin_d = bus.up_i ? (bin_q + ONE) : (bin_q - ONE);
        end
`else
        bin_d = bus.up_i ? (bin_q + ONE) : (bin_q - ONE);
`endif
      end
      default:   bin_d = bin_q;
    endcase
    gray_d = W'(bin2gray(GRAY_MAX_W'(bin_d)));
    zero_d = (bin_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
      zero_q <= (RST_BIN == '0);
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      zero_q <= zero_d;
    end
  end

  assign bus.bin_o  = bin_q;
  assign bus.gray_o = gray_q;
  assign bus.wrap_o = wrap_q;
  assign bus.zero_o = zero_q;

endmodule

// File: rtl/gray_counter_ud.sv
// Up/down counter with registered binary and Gray outputs, wrap pulse and zero flag.
// Optional GRAY_COUNTER_UD_SATURATE_EN (see gray_encode_reg) selects saturating ends.
module gray_counter_ud #(
  parameter int unsigned COUNTER_WIDTH = 4,
  parameter int unsigned RESET_VALUE   = 0
) (
  input  logic                     Clk,
  input  logic                     Reset_n_in,
  input  logic                     Clear_in,
  input  logic                     Enable_in,
  input  logic                     Up_in,
  input  logic                     Load_in,
  input  logic [COUNTER_WIDTH-1:0] LoadValue_in,
  output logic [COUNTER_WIDTH-1:0] GrayCount_out,
  output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
  output logic                     Wrap_out,
  output logic                     Zero_out
);

  gray_counter_ud_if #(.W(COUNTER_WIDTH)) bus_if ();

  assign bus_if.clear_i      = Clear_in;
  assign bus_if.load_i       = Load_in;
  assign bus_if.enable_i     = Enable_in;
  assign bus_if.up_i         = Up_in;
  assign bus_if.load_value_i = LoadValue_in;

  gray_encode_reg #(
    .W           (COUNTER_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_core (
    .clk   (Clk),
    .rst_n (Reset_n_in),
    .bus   (bus_if.slave)
  );

  assign GrayCount_out   = bus_if.gray_o;
  assign BinaryCount_out = bus_if.bin_o;
  assign Wrap_out        = bus_if.wrap_o;
  assign Zero_out        = bus_if.zero_o;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Testbench for gray_counter_ud (COUNTER_WIDTH=4, RESET_VALUE=0): vector table,
// directed corner sequences and random stimulus against an arithmetic reference model.
`timescale 1ns/1ps
module tb_gray_counter_ud;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;
`ifdef GRAY_COUNTER_UD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  gray_counter_ud_if #(.W(W)) tif ();

  gray_counter_ud #(.COUNTER_WIDTH(W), .RESET_VALUE(0)) dut (
    .Clk             (clk),
    .Reset_n_in      (rst_n),
    .Clear_in        (tif.clear_i),
    .Enable_in       (tif.enable_i),
    .Up_in           (tif.up_i),
    .Load_in         (tif.load_i),
    .LoadValue_in    (tif.load_value_i),
    .GrayCount_out   (tif.gray_o),
    .BinaryCount_out (tif.bin_o),
    .Wrap_out        (tif.wrap_o),
    .Zero_out        (tif.zero_o)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state: count as a plain integer, plus the expected wrap pulse.
  int m_bin  = 0;
  bit m_wrap = 1'b0;

  // Reflected Gray sequence built by mirroring, indexed by binary count.
  logic [W-1:0] gseq [0:MAXV];

  typedef struct {
    bit clr;
    bit ld;
    bit en;
    bit up;
    int lv;
    int exp_bin;
    bit exp_wrap;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int tb_gray2bin(input logic [W-1:0] g);
    for (int i = 0; i <= MAXV; i++) begin
      if (gseq[i] == g) return i;
    end
    return -1;
  endfunction

  task automatic drive(input bit clr, input bit ld, input bit en, input bit up, input int lv);
    tif.clear_i      = clr;
    tif.load_i       = ld;
    tif.enable_i     = en;
    tif.up_i         = up;
    tif.load_value_i = W'(lv);
  endtask

  task automatic model_step(input bit clr, input bit ld, input bit en, input bit up, input int lv);
    int raw;
    m_wrap = 1'b0;
    if (clr) begin
      m_bin = 0;
    end else if (ld) begin
      m_bin = lv;
    end else if (en) begin
      raw    = m_bin + (up ? 1 : -1);
      m_wrap = (raw < 0) || (raw > MAXV);
      if (!m_wrap)  m_bin = raw;
      else if (!SAT) m_bin = (raw + MAXV + 1) % (MAXV + 1);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":bin"},  int'(tif.bin_o),  m_bin);
    check({tag, ":gray"}, int'(tif.gray_o), int'(gseq[m_bin]));
    check({tag, ":wrap"}, int'(tif.wrap_o), int'(m_wrap));
    check({tag, ":zero"}, int'(tif.zero_o), int'(m_bin == 0));
    check({tag, ":g2b"},  tb_gray2bin(tif.gray_o), int'(tif.bin_o));
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic run_cycle(input string tag, input bit clr, input bit ld, input bit en,
                           input bit up, input int lv);
    logic [W-1:0] g_prev;
    int           b_prev;
    g_prev = tif.gray_o;
    b_prev = m_bin;
    drive(clr, ld, en, up, lv);
    @(posedge clk);
    model_step(clr, ld, en, up, lv);
    @(negedge clk);
    check_outputs(tag);
    if (!clr && !ld && en && (m_bin != b_prev))
      check({tag, ":hamming"}, $countones(tif.gray_o ^ g_prev), 1);
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    m_bin  = 0;
    m_wrap = 1'b0;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int wraps;

    gseq[0] = '0;
    for (int k = 0; k < W; k++) begin
      for (int i = 0; i < (1 << k); i++) begin
        gseq[(1 << k) + i] = gseq[(1 << k) - 1 - i] | W'(1 << k);
      end
    end

    //             clr ld en up lv  bin                 wrap
    tbl[0]  = '{0, 0, 1, 1, 0,  1,                  0};
    tbl[1]  = '{0, 1, 1, 0, 14, 14,                 0};
    tbl[2]  = '{0, 0, 1, 1, 0,  15,                 0};
    tbl[3]  = '{0, 0, 1, 1, 0,  (SAT ? 15 : 0),     1};
    tbl[4]  = '{0, 0, 0, 1, 5,  (SAT ? 15 : 0),     0};
    tbl[5]  = '{0, 1, 0, 1, 0,  0,                  0};
    tbl[6]  = '{0, 0, 1, 0, 0,  (SAT ? 0 : 15),     1};
    tbl[7]  = '{1, 1, 1, 1, 7,  0,                  0};
    tbl[8]  = '{0, 1, 0, 0, 9,  9,                  0};
    tbl[9]  = '{0, 0, 1, 0, 0,  8,                  0};
    tbl[10] = '{0, 0, 1, 1, 0,  9,                  0};
    tbl[11] = '{1, 1, 1, 1, 3,  0,                  0};

    drive(0, 0, 0, 0, 0);
    #1;
    apply_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].lv);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d:bin", i),  int'(tif.bin_o),  tbl[i].exp_bin);
      check($sformatf("tbl%0d:gray", i), int'(tif.gray_o), int'(gseq[tbl[i].exp_bin]));
      check($sformatf("tbl%0d:wrap", i), int'(tif.wrap_o), int'(tbl[i].exp_wrap));
      check($sformatf("tbl%0d:zero", i), int'(tif.zero_o), int'(tbl[i].exp_bin == 0));
    end
    m_bin  = tbl[11].exp_bin;
    m_wrap = 1'b0;

    // Full up sweep from reset: one wrap after the all-ones step.
    apply_reset();
    wraps = 0;
    for (int i = 0; i < 17; i++) begin
      run_cycle("up17", 0, 0, 1, 1, 0);
      if (tif.wrap_o) wraps++;
    end
    check("up17:wraps", wraps, SAT ? 2 : 1);

    // Load 1 then step down twice through zero.
    run_cycle("ld1", 0, 1, 0, 0, 1);
    run_cycle("dn1", 0, 0, 1, 0, 0);
    run_cycle("dn2", 0, 0, 1, 0, 0);

    // Asynchronous reset between edges while poised to wrap.
    run_cycle("ld15", 0, 1, 0, 0, 15);
    drive(0, 0, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_bin  = 0;
    m_wrap = 1'b0;
    check_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    rst_n = 1'b1;
    run_cycle("post_rst_hold", 0, 0, 0, 1, 0);
    run_cycle("post_rst_up",   0, 0, 1, 1, 0);

    // Twenty up steps from zero: saturating build sticks at all-ones.
    apply_reset();
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle("up20", 0, 0, 1, 1, 0);
      if (tif.wrap_o) wraps++;
    end
    check("up20:final", int'(tif.bin_o), SAT ? 15 : 4);
    check("up20:wraps", wraps, SAT ? 5 : 1);

    for (int i = 0; i < 10000; i++) begin
      run_cycle("rnd",
                ($urandom_range(0, 31) == 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                int'($urandom_range(0, MAXV)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
